// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - programmable serial pattern-detection run controller
// Optional first-match position capture: define SEQ_DETECT_CTRL_FIRST_POS_EN.
module seq_detect_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               done,
  output logic               timeout_flag,
  output logic               cfg_err,
  output logic [TO_W-1:0]    first_pos
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_q, state_n;
  logic [MAX_LEN-2:0] hist_q, hist_n;
  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n, fill_q, fill_n;
  logic               ovl_q, ovl_n;
  logic [CNT_W-1:0]   tgt_q, tgt_n, cnt_q, cnt_n;
  logic [TO_W-1:0]    tmo_q, tmo_n, timer_q, timer_n;
  logic               match_q, match_n, tflag_q, tflag_n, err_q, err_n;

  logic               len_ok, do_start, hit, tgt_hit, to_hit;
  logic [MAX_LEN-1:0] shifted, mask;
  logic [LEN_W:0]     fill_p1;
  logic [CNT_W-1:0]   cnt_inc;

  assign len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  assign do_start = start && !abort && (state_q != RUN) && len_ok;
  // Only the newest MAX_LEN bits matter; the oldest stored bit falls off here.
  assign shifted  = {hist_q, x};
  assign mask     = ~({MAX_LEN{1'b1}} << len_q);
  assign fill_p1  = {1'b0, fill_q} + (LEN_W+1)'(1);
  assign hit      = (state_q == RUN) && !abort && x_valid &&
                    (fill_p1 >= {1'b0, len_q}) &&
                    (((shifted ^ pat_q) & mask) == '0);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign tgt_hit  = hit && (tgt_q != '0) && (cnt_inc == tgt_q);
  assign to_hit   = (tmo_q != '0) && ((timer_q + TO_W'(1)) == tmo_q);

  always_comb begin
    state_n = state_q;
    hist_n  = hist_q;
    pat_n   = pat_q;
    len_n   = len_q;
    fill_n  = fill_q;
    ovl_n   = ovl_q;
    tgt_n   = tgt_q;
    cnt_n   = cnt_q;
    tmo_n   = tmo_q;
    timer_n = timer_q;
    tflag_n = tflag_q;
    match_n = 1'b0;
    err_n   = 1'b0;
    case (state_q)
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          if (tmo_q != '0) timer_n = timer_q + TO_W'(1);
          if (x_valid) begin
            hist_n = shifted[MAX_LEN-2:0];
            if (hit && !ovl_q)    fill_n = '0;
            else if (fill_q < len_q) fill_n = fill_q + LEN_W'(1);
          end
          if (hit) begin
            match_n = 1'b1;
            cnt_n   = cnt_inc;
          end
          // A target-reaching match outranks a coincident timeout.
          if (tgt_hit) begin
            state_n = DONE;
          end else if (to_hit) begin
            state_n = DONE;
            tflag_n = 1'b1;
          end
        end
      end
      IDLE, DONE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (do_start) begin
          state_n = RUN;
          pat_n   = cfg_pattern;
          len_n   = cfg_len;
          ovl_n   = cfg_overlap;
          tgt_n   = cfg_target;
          tmo_n   = cfg_timeout;
          hist_n  = '0;
          fill_n  = '0;
          timer_n = '0;
          cnt_n   = '0;
          tflag_n = 1'b0;
        end else if (start) begin
          err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      timer_q <= '0;
      tflag_q <= 1'b0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      hist_q  <= hist_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      fill_q  <= fill_n;
      ovl_q   <= ovl_n;
      tgt_q   <= tgt_n;
      cnt_q   <= cnt_n;
      tmo_q   <= tmo_n;
      timer_q <= timer_n;
      tflag_q <= tflag_n;
      match_q <= match_n;
      err_q   <= err_n;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign match        = match_q;
  assign match_count  = cnt_q;
  assign timeout_flag = tflag_q;
  assign cfg_err      = err_q;

`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
  logic [TO_W-1:0] smp_q, fpos_q, smp_inc;

  assign smp_inc = (&smp_q) ? smp_q : smp_q + TO_W'(1);

  // A zero match count marks the first hit of the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp_q  <= '0;
      fpos_q <= '0;
    end else if (do_start) begin
      smp_q  <= '0;
      fpos_q <= '0;
    end else if ((state_q == RUN) && !abort && x_valid) begin
      smp_q <= smp_inc;
      if (hit && (cnt_q == '0)) fpos_q <= smp_inc;
    end
  end

  assign first_pos = fpos_q;
`else
  assign first_pos = '0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic [CNT_W-1:0]   cfg_target = '0;
  logic [TO_W-1:0]    cfg_timeout = '0;
  logic               start = 1'b0, abort = 1'b0, x = 1'b0, x_valid = 1'b0;
  logic               busy, match, done, timeout_flag, cfg_err;
  logic [CNT_W-1:0]   match_count;
  logic [TO_W-1:0]    first_pos;
  logic [28:0]        obs;

  int n_cmp = 0;
  int n_err = 0;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .cfg_timeout(cfg_timeout),
    .start(start), .abort(abort), .x(x), .x_valid(x_valid), .busy(busy),
    .match(match), .match_count(match_count), .done(done),
    .timeout_flag(timeout_flag), .cfg_err(cfg_err), .first_pos(first_pos)
  );

  always #5 clk = ~clk;
  assign obs = {busy, done, match, match_count, timeout_flag, cfg_err, first_pos};

  // Reference model: run = list of sampled bits plus "fresh" bits since the last consumption.
  int                 m_state, m_len, m_target, m_tmo, m_cnt, m_cyc, m_fresh, m_nsamp, m_fpos;
  logic [MAX_LEN-1:0] m_pat;
  bit                 m_ovl, m_match, m_tflag, m_err;
  bit                 m_bits[$];

  function automatic void model_reset();
    m_state = 0; m_len = 0; m_target = 0; m_tmo = 0; m_cnt = 0; m_cyc = 0;
    m_fresh = 0; m_nsamp = 0; m_fpos = 0; m_pat = '0; m_ovl = 0;
    m_match = 0; m_tflag = 0; m_err = 0;
    m_bits.delete();
  endfunction

  function automatic void model_edge();
    bit hit;
    hit = 0;
    m_match = 0;
    m_err = 0;
    if (abort) begin
      m_state = 0;
    end else if (m_state != 1) begin
      if (start) begin
        if (cfg_len >= 1 && int'(cfg_len) <= MAX_LEN) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
          m_target = int'(cfg_target); m_tmo = int'(cfg_timeout);
          m_bits.delete(); m_fresh = 0; m_cyc = 0; m_cnt = 0; m_tflag = 0;
          m_nsamp = 0; m_fpos = 0; m_state = 1;
        end else begin
          m_err = 1;
        end
      end
    end else begin
      m_cyc++;
      if (x_valid) begin
        m_bits.push_back(x);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        if (m_nsamp < 65535) m_nsamp++;
        m_fresh++;
        if (m_fresh >= m_len) begin
          hit = 1;
          for (int i = 0; i < m_len; i++)
            if (m_bits[m_bits.size()-1-i] != m_pat[i]) hit = 0;
        end
      end
      if (hit) begin
        if (m_cnt == 0) m_fpos = m_nsamp;
        if (m_cnt < 255) m_cnt++;
        m_match = 1;
        if (!m_ovl) m_fresh = 0;
      end
      if (hit && m_target != 0 && m_cnt == m_target) m_state = 2;
      else if (m_tmo != 0 && m_cyc == m_tmo) begin
        m_state = 2;
        m_tflag = 1;
      end
    end
  endfunction

  function automatic logic [28:0] exp_vec();
    logic [15:0] fp;
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
    fp = 16'(m_fpos);
`else
    fp = '0;
`endif
    return {(m_state == 1), (m_state == 2), m_match, 8'(m_cnt), m_tflag, m_err, fp};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] p, input int len, input bit ovl, input int tgt, input int tmo);
    cfg_pattern = p;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cfg_target  = CNT_W'(tgt);
    cfg_timeout = TO_W'(tmo);
  endtask

  task automatic go_idle();
    start = 0; x_valid = 0; abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    tick();
    n_cmp++;
    if (obs !== 29'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1;
    tick();
    n_cmp++;
    if (obs !== 29'd0) begin
      n_err++; $display("FAIL post_reset_idle: got %h expected 0", obs);
    end
  endtask

  task automatic test_overlap();
    logic [5:0] seen;
    seen = '0;
    set_cfg(8'b1111, 4, 1, 0, 0);
    start = 1; tick(); start = 0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL overlap_busy: got %b expected 1", busy);
    end
    x_valid = 1; x = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen[i] = match;
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++; $display("FAIL overlap_cycle%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_cmp++;
    if (seen !== 6'b111000 || match_count !== 8'd3 || busy !== 1'b1) begin
      n_err++; $display("FAIL overlap_result: got seen=%b cnt=%0d busy=%b expected seen=111000 cnt=3 busy=1",
                        seen, match_count, busy);
    end
    go_idle();
  endtask

  task automatic test_nonoverlap();
    logic [7:0] seen;
    seen = '0;
    set_cfg(8'b1111, 4, 0, 0, 0);
    start = 1; tick(); start = 0;
    x_valid = 1; x = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen[i] = match;
    end
    n_cmp++;
    if (seen !== 8'b10001000 || match_count !== 8'd2) begin
      n_err++; $display("FAIL nonoverlap_result: got seen=%b cnt=%0d expected seen=10001000 cnt=2",
                        seen, match_count);
    end
    go_idle();
  endtask

  task automatic test_target();
    logic [4:0] stream;
    logic [4:0] seen;
    stream = 5'b10101;
    seen = '0;
    set_cfg(8'b101, 3, 1, 2, 0);
    start = 1; tick(); start = 0;
    x_valid = 1;
    for (int i = 0; i < 5; i++) begin
      x = stream[i];
      tick();
      seen[i] = match;
    end
    n_cmp++;
    if (seen !== 5'b10100 || done !== 1'b1 || match !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL target_finish: got seen=%b done=%b match=%b busy=%b expected 10100 1 1 0",
                        seen, done, match, busy);
    end
    x_valid = 0;
    tick();
    n_cmp++;
    if (done !== 1'b1 || match !== 1'b0 || match_count !== 8'd2) begin
      n_err++; $display("FAIL target_hold: got done=%b match=%b cnt=%0d expected 1 0 2", done, match, match_count);
    end
  endtask

  task automatic test_abort_start();
    set_cfg(8'b1, 1, 1, 0, 0);
    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || match_count !== 8'd2) begin
      n_err++; $display("FAIL abort_with_start: got busy=%b done=%b cnt=%0d expected 0 0 2", busy, done, match_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    set_cfg(8'b1111, 4, 1, 0, 10);
    start = 1; tick(); start = 0;
    x_valid = 1; x = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n !== 10 || timeout_flag !== 1'b1 || match_count !== 8'd0) begin
      n_err++; $display("FAIL timeout_run: got cycles=%0d tflag=%b cnt=%0d expected 10 1 0", n, timeout_flag, match_count);
    end
    go_idle();
  endtask

  task automatic test_cfg_err();
    set_cfg(8'b1, 0, 1, 0, 0);
    start = 1; tick(); start = 0;
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_err_len0: got err=%b busy=%b expected 1 0", cfg_err, busy);
    end
    tick();
    n_cmp++;
    if (cfg_err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL cfg_err_pulse: got err=%b busy=%b done=%b expected 0 0 0", cfg_err, busy, done);
    end
    set_cfg(8'b1, 9, 1, 0, 0);
    start = 1; tick(); start = 0;
    n_cmp++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL cfg_err_len9: got err=%b busy=%b expected 1 0", cfg_err, busy);
    end
    tick();
  endtask

  task automatic test_first_pos();
    logic [6:0] stream;
    logic [15:0] want;
    stream = 7'b1111100;
`ifdef SEQ_DETECT_CTRL_FIRST_POS_EN
    want = 16'd6;
`else
    want = 16'd0;
`endif
    set_cfg(8'b1111, 4, 1, 0, 0);
    start = 1; tick(); start = 0;
    x_valid = 1;
    for (int i = 0; i < 7; i++) begin
      x = stream[i];
      tick();
    end
    n_cmp++;
    if (first_pos !== want || match_count !== 8'd2) begin
      n_err++; $display("FAIL first_pos: got pos=%0d cnt=%0d expected pos=%0d cnt=2", first_pos, match_count, want);
    end
    go_idle();
  endtask

  task automatic test_rst_mid_run();
    set_cfg(8'b11, 2, 1, 0, 0);
    start = 1; tick(); start = 0;
    x_valid = 1; x = 1;
    repeat (3) tick();
    #2 rst = 0;
    #1;
    model_reset();
    n_cmp++;
    if (obs !== 29'd0) begin
      n_err++; $display("FAIL rst_mid_run: got %h expected 0", obs);
    end
    tick();
    rst = 1; x_valid = 0;
    tick();
    n_cmp++;
    if (obs !== exp_vec()) begin
      n_err++; $display("FAIL rst_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    int errs_here;
    errs_here = 0;
    for (int c = 0; c < 3000 && errs_here < 20; c++) begin
      start = ($urandom_range(0, 15) == 0);
      abort = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 9) == 0) cfg_len = ($urandom_range(0, 1) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(9, 15));
      else if ($urandom_range(0, 3) == 0) cfg_len = LEN_W'($urandom_range(5, 8));
      else cfg_len = LEN_W'($urandom_range(1, 4));
      cfg_pattern = MAX_LEN'($urandom);
      cfg_overlap = 1'($urandom_range(0, 1));
      cfg_target  = CNT_W'($urandom_range(0, 4));
      cfg_timeout = ($urandom_range(0, 3) == 0) ? TO_W'(0) : TO_W'($urandom_range(1, 40));
      x       = 1'($urandom_range(0, 1));
      x_valid = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if (obs !== exp_vec()) begin
        n_err++; errs_here++;
        $display("FAIL random_cycle%0d: got %h expected %h", c, obs, exp_vec());
      end
    end
    go_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_target();
    test_abort_start();
    test_timeout();
    test_cfg_err();
    test_first_pos();
    test_rst_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
